// File: rtl/sqrt_pkg.sv
// Shared constants for the SQRT / fixed_square pair: widths, iteration count, FSM encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sqrt_pkg;

  // Operand is unsigned Q8.4; the square is returned as a plain 16-bit integer.
  localparam int IN_W   = 12;
  localparam int FRAC_W = 4;
  localparam int OUT_W  = 2 * IN_W - 2 * FRAC_W;
  localparam int ITER   = IN_W;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/shift_add_mul_core.sv
// Unsigned shift-add multiplier datapath, one multiplier bit per step, squaring its operand.
// Latency: W steps after start; done is high during the step that retires the last bit.
// Backpressure: none; the controller decides when to start and when to step.
//
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   start       load operand into mcand/mplier, clear product and count
//   operand     value to be squared (W bits)
//   step        perform one shift-add iteration
//   done        combinational: this step is the final iteration
//   prod_hi     product[2W-1:2F-1]: integer part plus the half-LSB used for rounding
module shift_add_mul_core
  import sqrt_pkg::*;
#(
  parameter int W = IN_W,
  parameter int F = FRAC_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [W-1:0]     operand,
  input  logic             step,
  output logic             done,
  output logic [2*W-2*F:0] prod_hi
);

  localparam int CNT_W = $clog2(W + 1);

  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplier;
  logic [2*W-1:0]   product;
  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
    end else if (start) begin
      mcand   <= {{W{1'b0}}, operand};
      mplier  <= operand;
      product <= '0;
      count   <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
    end
  end

  assign done    = step && (count == CNT_W'(W - 1));
  // Low 2F-1 fraction bits never influence a round-half-up result.
  assign prod_hi = product[2*W-1:2*F-1];

endmodule

// File: rtl/fixed_square.sv
// Sequential squarer: unsigned Q8.4 in, square rounded half-up to a 16-bit integer out.
// Latency: IN_VALID at edge N -> OUT_VALID for one cycle from edge N+13; next capture at N+15.
// Backpressure: none; IN_VALID is ignored while BUSY (including the result cycle).
//
// Ports:
//   CLK        clock, all state updates on posedge
//   RST_N      asynchronous active-low reset; aborts any operation in flight
//   IN_VALID   one-cycle strobe qualifying IN
//   IN         operand, unsigned Q(IN_W-FRAC_W).FRAC_W
//   BUSY       high whenever the FSM is not idle
//   OUT_VALID  one-cycle result strobe
//   OUT        rounded square; zero whenever OUT_VALID is low
// OUT_W must equal 2*IN_W-2*FRAC_W.
module fixed_square #(
  parameter int IN_W   = sqrt_pkg::IN_W,
  parameter int FRAC_W = sqrt_pkg::FRAC_W,
  parameter int OUT_W  = sqrt_pkg::OUT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  input  logic [IN_W-1:0]  IN,
  output logic             BUSY,
  output logic             OUT_VALID,
  output logic [OUT_W-1:0] OUT
);

  import sqrt_pkg::*;

  state_t           state;
  logic             core_start;
  logic             core_step;
  logic             core_done;
  logic [OUT_W:0]   prod_hi;
  logic [OUT_W:0]   round_sum;
  logic [OUT_W-1:0] rounded;
  logic [OUT_W-1:0] out_q;
  logic             out_vld_q;

  assign core_start = (state == ST_IDLE) && IN_VALID;
  assign core_step  = (state == ST_CALC);

  shift_add_mul_core #(
    .W (IN_W),
    .F (FRAC_W)
  ) u_core (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .start   (core_start),
    .operand (IN),
    .step    (core_step),
    .done    (core_done),
    .prod_hi (prod_hi)
  );

  // prod_hi[0] is the first dropped fraction bit: adding it rounds half up.
  // The carry-out cannot occur for full-range inputs but is clamped anyway.
  assign round_sum = {1'b0, prod_hi[OUT_W:1]} + {{OUT_W{1'b0}}, prod_hi[0]};
  assign rounded   = round_sum[OUT_W] ? {OUT_W{1'b1}} : round_sum[OUT_W-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (core_done) begin
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          out_q     <= rounded;
          out_vld_q <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          // Clearing here keeps OUT at zero outside the result cycle.
          out_q     <= '0;
          out_vld_q <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY      = (state != ST_IDLE);
  assign OUT_VALID = out_vld_q;
  assign OUT       = out_q;

endmodule

// File: tb/tb_fixed_square.sv
module tb_fixed_square;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic [11:0] IN;
  logic        BUSY;
  logic        OUT_VALID;
  logic [15:0] OUT;

  always #5 CLK = ~CLK;

  fixed_square dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN        (IN),
    .BUSY      (BUSY),
    .OUT_VALID (OUT_VALID),
    .OUT       (OUT)
  );

  typedef struct {
    int unsigned val;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned next_free = 0;
  int unsigned last_acc = 0;
  bit          acc_vld = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: x is Q8.4, so x^2 carries 8 fraction bits; round half up.
  function automatic int unsigned ref_sq(input logic [11:0] x);
    int unsigned r;
    r = (int'(x) * int'(x) + 128) / 256;
    if (r > 65535) r = 65535;
    return r;
  endfunction

  // Monitor: samples on the falling edge, cyc = number of rising edges so far.
  always @(negedge CLK) begin
    bit   exp_busy;
    exp_t e;
    exp_busy = acc_vld && (cyc >= last_acc) && (cyc <= last_acc + 13);
    if (RST_N === 1'b1) begin
      checks++;
      if (BUSY !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, BUSY, exp_busy);
      end
      if (OUT_VALID === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result cyc=%0d got OUT=%0d want no OUT_VALID", cyc, OUT);
        end else begin
          e = sb.pop_front();
          if (OUT !== 16'(e.val) || cyc != e.at) begin
            errors++;
            $display("FAIL result got OUT=%0d at edge %0d want OUT=%0d at edge %0d",
                     OUT, cyc, e.val, e.at);
          end
        end
      end else begin
        checks++;
        if (OUT_VALID !== 1'b0 || OUT !== 16'd0) begin
          errors++;
          $display("FAIL idle_out cyc=%0d got OUT_VALID=%b OUT=%0d want 0/0", cyc, OUT_VALID, OUT);
        end
      end
    end
  end

  // One driven cycle; the model decides whether the upcoming edge captures.
  task automatic drive(input bit v, input logic [11:0] x);
    int unsigned e;
    exp_t t;
    @(negedge CLK);
    IN_VALID = v;
    IN       = x;
    e        = cyc + 1;
    if (v && e >= next_free) begin
      t.val = ref_sq(x);
      t.at  = e + 13;
      sb.push_back(t);
      last_acc  = e;
      acc_vld   = 1'b1;
      next_free = e + 15;
    end
  endtask

  task automatic idle_until_free();
    while (cyc + 1 < next_free) drive(1'b0, 12'($urandom));
  endtask

  task automatic send(input logic [11:0] x);
    drive(1'b1, x);
    idle_until_free();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST_N    = 1'b0;
    IN_VALID = 1'b0;
    sb.delete();
    acc_vld   = 1'b0;
    next_free = 0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || OUT_VALID !== 1'b0 || OUT !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got BUSY=%b OUT_VALID=%b OUT=%0d want 0/0/0", BUSY, OUT_VALID, OUT);
    end
    repeat (2) @(negedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  initial begin
    logic [11:0] x;
    int          n;
    RST_N    = 1'b0;
    IN_VALID = 1'b0;
    IN       = '0;
    do_reset();

    // Directed: unity, full scale, rounding boundaries, zero.
    send(12'h010);
    send(12'hFFF);
    send(12'h028);
    send(12'h02C);
    send(12'h00C);
    send(12'h00B);
    send(12'h000);

    // Second strobe while busy is ignored.
    drive(1'b1, 12'h020);
    repeat (4) drive(1'b0, 12'h000);
    drive(1'b1, 12'hFFF);
    idle_until_free();

    // Reset mid-calculation aborts; then a normal operation.
    drive(1'b1, 12'h123);
    repeat (5) drive(1'b0, 12'h000);
    do_reset();
    send(12'h030);

    // Randomized traffic, including long stretches of IN_VALID held high.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) drive(1'b0, 12'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(16, 35);
        for (int j = 0; j < n; j++) drive(1'b1, 12'($urandom));
        drive(1'b0, 12'h000);
        idle_until_free();
      end else begin
        case ($urandom_range(0, 7))
          0:       x = 12'hFFF;
          1:       x = 12'h000;
          default: x = 12'($urandom);
        endcase
        send(x);
      end
    end

    // Drain with a bounded wait.
    for (int k = 0; k < 40 && sb.size() > 0; k++) drive(1'b0, 12'h000);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending results want 0", sb.size());
    end
    repeat (3) drive(1'b0, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
